// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file for the MIPS pipeline.
// Selects the MEM/WB write-back value, commits it, and serves two bypassed read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_WB_RegWrite,
  input  logic              I_WB_MemtoReg,
  input  logic [DATA_W-1:0] I_ReDat_Mem,
  input  logic [DATA_W-1:0] I_ALU_Res,
  input  logic [ADDR_W-1:0] I_Addr_Reg_Wri,
  input  logic [ADDR_W-1:0] I_Addr_Rs,
  input  logic [ADDR_W-1:0] I_Addr_Rt,
  output logic [DATA_W-1:0] O_Dat_Rs,
  output logic [DATA_W-1:0] O_Dat_Rt,
  output logic [DATA_W-1:0] O_WB_Data,
  output logic              O_WB_Valid,
  output logic [31:0]       O_Wri_Count
);

  localparam int NREG = 1 << ADDR_W;

  // There is no valid/ready pair: every cycle presents one write-back slot,
  // which is always accepted; I_WB_RegWrite alone qualifies the write.
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [31:0]       wri_count_q;
  logic [31:0]       wri_count_d;
  logic [DATA_W-1:0] wb_data;
  logic              commit;

  always_comb begin
    wb_data = I_WB_MemtoReg ? I_ReDat_Mem : I_ALU_Res;
    commit  = I_WB_RegWrite && (I_Addr_Reg_Wri != '0) && !rst;
  end

  always_comb begin
    regs_d      = regs_q;
    wri_count_d = wri_count_q;
    if (rst) begin
      regs_d      = '{default: '0};
      wri_count_d = '0;
    end else if (commit) begin
      regs_d[I_Addr_Reg_Wri] = wb_data;
      wri_count_d            = wri_count_q + 32'd1;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    regs_q      <= regs_d;
    wri_count_q <= wri_count_d;
  end

  // Write-through bypass lets decode see a value in the same cycle it commits.
  always_comb begin
    O_Dat_Rs = regs_q[I_Addr_Rs];
    if (rst || (I_Addr_Rs == '0)) begin
      O_Dat_Rs = '0;
    end else if (commit && (I_Addr_Rs == I_Addr_Reg_Wri)) begin
      O_Dat_Rs = wb_data;
    end
  end

  always_comb begin
    O_Dat_Rt = regs_q[I_Addr_Rt];
    if (rst || (I_Addr_Rt == '0)) begin
      O_Dat_Rt = '0;
    end else if (commit && (I_Addr_Rt == I_Addr_Reg_Wri)) begin
      O_Dat_Rt = wb_data;
    end
  end

  always_comb begin
    O_WB_Data   = wb_data;
    O_WB_Valid  = commit;
    O_Wri_Count = wri_count_q;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write/read, bypass, register zero,
// reset priority and write-counter wrap, with hand-computed expectations.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        wb_regwrite;
  logic        wb_memtoreg;
  logic [31:0] redat_mem;
  logic [31:0] alu_res;
  logic [4:0]  addr_wri;
  logic [4:0]  addr_rs;
  logic [4:0]  addr_rt;
  logic [31:0] dat_rs;
  logic [31:0] dat_rt;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic [31:0] wri_count;

  int checks = 0;
  int errors = 0;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .I_WB_RegWrite  (wb_regwrite),
    .I_WB_MemtoReg  (wb_memtoreg),
    .I_ReDat_Mem    (redat_mem),
    .I_ALU_Res      (alu_res),
    .I_Addr_Reg_Wri (addr_wri),
    .I_Addr_Rs      (addr_rs),
    .I_Addr_Rt      (addr_rt),
    .O_Dat_Rs       (dat_rs),
    .O_Dat_Rt       (dat_rt),
    .O_WB_Data      (wb_data),
    .O_WB_Valid     (wb_valid),
    .O_Wri_Count    (wri_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic we, input logic m2r, input logic [31:0] mem,
                          input logic [31:0] alu, input logic [4:0] wa);
    wb_regwrite = we;
    wb_memtoreg = m2r;
    redat_mem   = mem;
    alu_res     = alu;
    addr_wri    = wa;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    addr_rs = 5'd0;
    addr_rt = 5'd0;
    tick();
    tick();

    // During reset: reads 0, no commit, mux still live, count 0
    drive_wb(1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd3);
    addr_rs = 5'd3;
    addr_rt = 5'd31;
    #1;
    check("rst_rs", dat_rs, 32'h0);
    check("rst_rt", dat_rt, 32'h0);
    check("rst_valid", {31'b0, wb_valid}, 32'h0);
    check("rst_wbdata", wb_data, 32'h0000_0011);
    check("rst_count", wri_count, 32'h0);

    // A few writes, then reset must clear every register and the count
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive_wb(1'b1, 1'b0, 32'h0, 32'h1000_0000 + i, i[4:0]);
      tick();
    end
    drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    check("pre_rst_count", wri_count, 32'd6);
    addr_rs = 5'd4;
    #1;
    check("pre_rst_reg4", dat_rs, 32'h1000_0004);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addr_rs = i[4:0];
      addr_rt = 5'(31 - i);
      #1;
      check("clr_rs", dat_rs, 32'h0);
      check("clr_rt", dat_rt, 32'h0);
    end
    check("clr_count", wri_count, 32'h0);

    // Basic write from ALU result
    drive_wb(1'b1, 1'b0, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 5'd5);
    #1;
    check("alu_wbdata", wb_data, 32'hDEAD_BEEF);
    check("alu_valid", {31'b0, wb_valid}, 32'h1);
    tick();
    drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    addr_rs = 5'd5;
    #1;
    check("alu_rd5", dat_rs, 32'hDEAD_BEEF);
    check("alu_count", wri_count, 32'd1);

    // Basic write from memory data into r31
    drive_wb(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0055, 5'd31);
    #1;
    check("mem_wbdata", wb_data, 32'h1234_5678);
    tick();
    drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    addr_rt = 5'd31;
    #1;
    check("mem_rd31", dat_rt, 32'h1234_5678);
    check("mem_count", wri_count, 32'd2);

    // Bypass: seed r7, then write 0xA5A5A5A5 with and without RegWrite
    drive_wb(1'b1, 1'b0, 32'h0, 32'h0101_0101, 5'd7);
    tick();
    drive_wb(1'b0, 1'b0, 32'h0, 32'hA5A5_A5A5, 5'd7);
    addr_rs = 5'd7;
    addr_rt = 5'd7;
    #1;
    check("nobyp_rs", dat_rs, 32'h0101_0101);
    check("nobyp_rt", dat_rt, 32'h0101_0101);
    check("nobyp_valid", {31'b0, wb_valid}, 32'h0);
    wb_regwrite = 1'b1;
    #1;
    check("byp_rs", dat_rs, 32'hA5A5_A5A5);
    check("byp_rt", dat_rt, 32'hA5A5_A5A5);
    check("byp_valid", {31'b0, wb_valid}, 32'h1);
    addr_rt = 5'd5;
    #1;
    check("byp_other", dat_rt, 32'hDEAD_BEEF);
    tick();
    drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("byp_after", dat_rs, 32'hA5A5_A5A5);
    check("byp_count", wri_count, 32'd4);

    // Register zero is never written nor counted
    drive_wb(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
    addr_rs = 5'd0;
    addr_rt = 5'd0;
    #1;
    check("r0_rs", dat_rs, 32'h0);
    check("r0_rt", dat_rt, 32'h0);
    check("r0_valid", {31'b0, wb_valid}, 32'h0);
    tick();
    drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("r0_after", dat_rs, 32'h0);
    check("r0_count", wri_count, 32'd4);

    // Unknown write-side inputs with RegWrite low leave state alone
    drive_wb(1'b0, 1'bx, 32'hx, 32'hx, 5'bx);
    tick();
    addr_rs = 5'd5;
    addr_rt = 5'd7;
    #1;
    check("x_rs", dat_rs, 32'hDEAD_BEEF);
    check("x_rt", dat_rt, 32'hA5A5_A5A5);
    check("x_count", wri_count, 32'd4);

    // Reset wins over a simultaneous valid write to r9
    drive_wb(1'b1, 1'b0, 32'h0, 32'h9999_9999, 5'd9);
    addr_rs = 5'd9;
    rst = 1'b1;
    #1;
    check("rp_rs_during", dat_rs, 32'h0);
    check("rp_valid", {31'b0, wb_valid}, 32'h0);
    check("rp_wbdata", wb_data, 32'h9999_9999);
    tick();
    rst = 1'b0;
    drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("rp_reg9", dat_rs, 32'h0);
    check("rp_reg5", dat_rt, 32'h0);
    check("rp_count", wri_count, 32'h0);

    // Counter wrap: preload 0xFFFFFFFF by backdoor, then one commit
    force dut.wri_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wri_count_q;
    tick();
    check("wrap_preload", wri_count, 32'hFFFF_FFFF);
    drive_wb(1'b1, 1'b0, 32'h0, 32'h0000_CAFE, 5'd2);
    tick();
    drive_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    addr_rs = 5'd2;
    #1;
    check("wrap_count", wri_count, 32'h0);
    check("wrap_reg2", dat_rs, 32'h0000_CAFE);
    tick();
    check("wrap_hold", wri_count, 32'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the 32-bit MIPS pipeline: consumes the MEM/WB buffer outputs, selects the write-back value, and commits it to a 32 x 32-bit register file. The block also serves the two decode-stage read ports with same-cycle write-through bypass and exports the write-back value for EX-stage forwarding. It sits between the MEM/WB buffer and the ID stage, closing the register write/read loop.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width (2^ADDR_W registers)
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- I_WB_RegWrite  in  1  write enable from MEM/WB
- I_WB_MemtoReg  in  1  1 = write memory read data, 0 = write ALU result
- I_ReDat_Mem  in  DATA_W  data memory read data from MEM/WB
- I_ALU_Res  in  DATA_W  ALU result from MEM/WB
- I_Addr_Reg_Wri  in  ADDR_W  destination register from MEM/WB
- I_Addr_Rs  in  ADDR_W  decode read address A
- I_Addr_Rt  in  ADDR_W  decode read address B
- O_Dat_Rs  out  DATA_W  read data A (combinational)
- O_Dat_Rt  out  DATA_W  read data B (combinational)
- O_WB_Data  out  DATA_W  selected write-back value (combinational), to forwarding unit
- O_WB_Valid  out  1  committed write this cycle (combinational)
- O_Wri_Count  out  32  registered count of committed writes

## Operation
- Write-back mux: O_WB_Data = I_WB_MemtoReg ? I_ReDat_Mem : I_ALU_Res; valid regardless of I_WB_RegWrite.
- Commit condition: commit = I_WB_RegWrite && (I_Addr_Reg_Wri != 0) && !rst. O_WB_Valid = commit.
- On rising clk with commit: reg[I_Addr_Reg_Wri] <= O_WB_Data; O_Wri_Count <= O_Wri_Count + 1.
- Register 0: hardwired zero; never written, reads always return 0, writes to it not counted.
- Read ports, each independently: if rst -> 0; else if address == 0 -> 0; else if commit && address == I_Addr_Reg_Wri -> O_WB_Data (bypass); else reg[address].
- Both read ports may hit the same register and the same bypass simultaneously; both return identical data.
- O_Wri_Count: unsigned 32-bit, wraps 0xFFFFFFFF -> 0x00000000 without flag.
- Reset (rst high at rising edge): all 32 registers <= 0, O_Wri_Count <= 0; rst overrides any simultaneous write. Asserting rst mid-stream discards the in-flight MEM/WB write.
- X/undriven inputs while I_WB_RegWrite = 0 must not alter state.

## Timing
- Write latency: value committed at edge N is visible from array reads in cycle N+1; visible via bypass already in cycle N (before the edge).
- Read latency: zero cycles (combinational from I_Addr_Rs/I_Addr_Rt and write-side inputs).
- O_WB_Data, O_WB_Valid: zero cycles from MEM/WB outputs.
- O_Wri_Count: updates one edge after commit asserted.
- Reset values: all registers 0, O_Wri_Count 0; O_Dat_Rs/O_Dat_Rt 0 while rst high; O_WB_Valid 0 while rst high; O_WB_Data follows mux even during reset.
- No handshake or stall: one write-back per cycle, always accepted.

## Test plan
- Reset: drive rst=1 one edge after random writes -> all 32 registers read 0, O_Wri_Count=0, O_Dat_Rs/Rt=0 during rst.
- Basic write/read: RegWrite=1, MemtoReg=0, ALU_Res=0xDEADBEEF, addr=5; next cycle Rs=5 -> O_Dat_Rs=0xDEADBEEF, O_Wri_Count=1; repeat with MemtoReg=1, ReDat_Mem=0x12345678, addr=31 -> Rt=31 returns 0x12345678.
- Bypass: same cycle write addr=7 data 0xA5A5A5A5, Rs=Rt=7 -> both outputs 0xA5A5A5A5 before the edge; with RegWrite=0 same stimulus -> old reg[7].
- Register zero: RegWrite=1, addr=0, ALU_Res=0xFFFFFFFF -> Rs=0 reads 0 same and next cycle, O_WB_Valid=0, O_Wri_Count unchanged.
- Reset priority: rst=1 and valid write to addr=9 same edge -> reg[9]=0 after, O_Wri_Count=0.
- Counter wrap: force 2^32-1 commits (or preload via backdoor to 0xFFFFFFFF) then one commit -> O_Wri_Count=0x00000000.
